// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman array front end: base codes,
// loader states and default array dimensions.
package sw_pkg;

   localparam int unsigned NUM_PE_DEF  = 8;
   localparam int unsigned SCORE_W_DEF = 10;
   localparam int unsigned LEN_W_DEF   = 16;

   localparam logic [1:0] BASE_A = 2'b00;
   localparam logic [1:0] BASE_C = 2'b01;
   localparam logic [1:0] BASE_G = 2'b10;
   localparam logic [1:0] BASE_T = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      LOAD,
      STREAM,
      DRAIN
   } loader_state_e;

endpackage

// File: rtl/sw_read_buffer.sv
// Short-read register file: one synchronous write port, one combinational
// read port. Addresses are sequenced by the loader.
module sw_read_buffer #(
   parameter  int unsigned NUM_PE = 8,
   localparam int unsigned AW     = $clog2(NUM_PE)
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [1:0]    wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [1:0]    rd_data_c
);

   logic [1:0] mem_q [NUM_PE];

   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_c = mem_q[rd_addr_i];

endmodule

// File: rtl/sw_array_loader.sv
// Front-end loader for PE0: captures a short read, shift-loads it into the
// array, streams the reference, then drains the pipeline and pulses done.
module sw_array_loader
   import sw_pkg::*;
#(
   parameter int unsigned NUM_PE  = NUM_PE_DEF,
   parameter int unsigned SCORE_W = SCORE_W_DEF,
   parameter int unsigned LEN_W   = LEN_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [LEN_W-1:0]   ref_len,
   output logic               busy,
   output logic               done,
   input  logic [1:0]         base_in,
   input  logic               base_valid,
   output logic               base_ready,
   output logic [SCORE_W-1:0] V_out,
   output logic [SCORE_W-1:0] F_out,
   output logic [1:0]         S_out,
   output logic               store_S_out,
   output logic [1:0]         T_out,
   output logic               init_out
);

   localparam int unsigned     PTR_W    = $clog2(NUM_PE);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_PE - 1);

   loader_state_e    state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;
   logic [1:0]       s_q, s_d;
   logic             store_q, store_d;
   logic [1:0]       t_q, t_d;
   logic             init_q, init_d;

   logic             wr_en;
   logic [PTR_W-1:0] rd_addr;
   logic [1:0]       rd_data;
   logic             hs;

   assign hs      = base_valid & ready_q;
   assign rd_addr = ptr_q - PTR_W'(1);

   sw_read_buffer #(
      .NUM_PE (NUM_PE)
   ) u_buf (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (ptr_q),
      .wr_data_i (base_in),
      .rd_addr_i (rd_addr),
      .rd_data_c (rd_data)
   );

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
         s_q     <= '0;
         store_q <= 1'b0;
         t_q     <= '0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         s_q     <= s_d;
         store_q <= store_d;
         t_q     <= t_d;
         init_q  <= init_d;
      end
   end

   // Next state; ptr_q doubles as capture/load pointer and drain counter
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ready_d = ready_q;
      s_d     = s_q;
      store_d = 1'b0;
      t_d     = t_q;
      init_d  = 1'b0;
      wr_en   = 1'b0;

      case (state_q)
         IDLE: begin
            // A done pulse still counts as busy, so start is ignored then.
            if (start && !done_q) begin
               state_d = CAPTURE;
               len_d   = ref_len;
               ptr_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               ready_d = 1'b1;
            end
         end
         CAPTURE: begin
            if (hs) begin
               wr_en = 1'b1;
               if (ptr_q == PTR_LAST) begin
                  // Last base bypasses the buffer straight onto S_out.
                  state_d = LOAD;
                  ready_d = 1'b0;
                  s_d     = base_in;
                  store_d = 1'b1;
               end else begin
                  ptr_d = ptr_q + PTR_W'(1);
               end
            end
         end
         LOAD: begin
            if (ptr_q != '0) begin
               ptr_d   = ptr_q - PTR_W'(1);
               s_d     = rd_data;
               store_d = 1'b1;
            end else if (len_q == '0) begin
               // The idle cycle leaving LOAD already counts as a drain cycle.
               state_d = DRAIN;
               ptr_d   = PTR_W'(1);
            end else begin
               state_d = STREAM;
               ready_d = 1'b1;
            end
         end
         STREAM: begin
            if (hs) begin
               t_d    = base_in;
               init_d = 1'b1;
               cnt_d  = cnt_q + LEN_W'(1);
               if (cnt_q == len_q - LEN_W'(1)) begin
                  state_d = DRAIN;
                  ready_d = 1'b0;
                  ptr_d   = '0;
               end
            end
         end
         DRAIN: begin
            if (ptr_q == PTR_LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               ptr_d = ptr_q + PTR_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign base_ready  = ready_q;
   assign V_out       = '0;
   assign F_out       = '0;
   assign S_out       = s_q;
   assign store_S_out = store_q;
   assign T_out       = t_q;
   assign init_out    = init_q;

endmodule

// File: tb/tb_sw_array_loader.sv
// Directed self-checking bench for sw_array_loader with a 6-PE array.
module tb_sw_array_loader;
   import sw_pkg::*;

   localparam int unsigned NPE = 6;
   localparam int unsigned SW  = 10;
   localparam int unsigned LW  = 16;

   logic          clk;
   logic          rst;
   logic          start;
   logic [LW-1:0] ref_len;
   logic          busy;
   logic          done;
   logic [1:0]    base_in;
   logic          base_valid;
   logic          base_ready;
   logic [SW-1:0] V_out;
   logic [SW-1:0] F_out;
   logic [1:0]    S_out;
   logic          store_S_out;
   logic [1:0]    T_out;
   logic          init_out;

   sw_array_loader #(.NUM_PE(NPE), .SCORE_W(SW), .LEN_W(LW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .ref_len     (ref_len),
      .busy        (busy),
      .done        (done),
      .base_in     (base_in),
      .base_valid  (base_valid),
      .base_ready  (base_ready),
      .V_out       (V_out),
      .F_out       (F_out),
      .S_out       (S_out),
      .store_S_out (store_S_out),
      .T_out       (T_out),
      .init_out    (init_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [1:0] rd_b [NPE];
   logic [1:0] rf_b [8];

   int          cyc;
   int          n_store, first_store, last_store, ready_load, overlap;
   int          n_init, n_done, done_cyc, vf_bad, hold_err, post_busy;
   logic        done_busy;
   logic [11:0] s_pk;
   logic [15:0] t_pk;
   logic [1:0]  t_prev;
   int          init_cyc [16];
   int          hs_cyc   [16];
   bit          poke;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      n_store = 0; first_store = 0; last_store = 0; ready_load = 0; overlap = 0;
      n_init = 0; n_done = 0; done_cyc = 0; vf_bad = 0; hold_err = 0;
      post_busy = 0; done_busy = 1'b1; s_pk = '0; t_pk = '0; t_prev = T_out;
   endtask

   // Advance one clock and log the post-edge outputs
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (V_out != '0 || F_out != '0) vf_bad++;
      if (store_S_out) begin
         if (n_store == 0) first_store = cyc;
         last_store = cyc;
         n_store++;
         s_pk = {s_pk[9:0], S_out};
         if (base_ready) ready_load++;
         if (init_out) overlap++;
      end
      if (init_out) begin
         if (n_init < 16) init_cyc[n_init] = cyc;
         n_init++;
         t_pk = {t_pk[13:0], T_out};
      end else if (busy && T_out !== t_prev) begin
         hold_err++;
      end
      t_prev = T_out;
      if (done) begin
         n_done++;
         done_cyc  = cyc;
         done_busy = busy;
      end
      if (poke) start = busy | done;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!base_ready && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_read();
      for (int i = 0; i < int'(NPE); i++) begin
         base_valid = 1'b1;
         base_in    = rd_b[i];
         wait_ready();
         tick();
      end
      base_valid = 1'b0;
   endtask

   task automatic run_job(input int len, input logic [15:0] gaps);
      int n;
      clear_log();
      start   = 1'b1;
      ref_len = LW'(len);
      tick();
      start   = 1'b0;
      ref_len = 16'hFFFF;
      send_read();
      for (int j = 0; j < len; j++) begin
         base_valid = 1'b0;
         wait_ready();
         if (gaps[j]) tick();
         base_valid = 1'b1;
         base_in    = rf_b[j];
         tick();
         hs_cyc[j] = cyc;
      end
      base_valid = 1'b0;
      n = 0;
      while (n_done == 0 && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) chk("done_timeout", 32'd0, 32'd1);
      repeat (8) begin
         tick();
         if (busy || base_ready) post_busy++;
      end
   endtask

   task automatic check_job(input string tag, input int len, input int span);
      int          hs_bad = 0;
      logic [15:0] t_exp  = '0;
      chk({tag, "_nstore"}, 32'(n_store), 32'd6);
      chk({tag, "_s_seq"}, 32'(s_pk), 32'(12'b00_11_01_00_01_00));
      chk({tag, "_store_run"}, 32'(last_store - first_store), 32'd5);
      chk({tag, "_ready_in_load"}, 32'(ready_load), 32'd0);
      chk({tag, "_store_init_overlap"}, 32'(overlap), 32'd0);
      chk({tag, "_ninit"}, 32'(n_init), 32'(len));
      if (len > 0) begin
         for (int j = 0; j < len; j++) begin
            t_exp = {t_exp[13:0], rf_b[j]};
            if (init_cyc[j] != hs_cyc[j]) hs_bad++;
         end
         chk({tag, "_t_seq"}, 32'(t_pk), 32'(t_exp));
         chk({tag, "_init_latency"}, 32'(hs_bad), 32'd0);
         chk({tag, "_init_span"}, 32'(init_cyc[len-1] - init_cyc[0]), 32'(span));
         chk({tag, "_store_init_gap"}, 32'(init_cyc[0] - last_store), 32'd2);
         chk({tag, "_drain_len"}, 32'(done_cyc - init_cyc[len-1]), 32'd6);
      end else begin
         chk({tag, "_drain_len"}, 32'(done_cyc - last_store), 32'd6);
      end
      chk({tag, "_ndone"}, 32'(n_done), 32'd1);
      chk({tag, "_busy_at_done"}, 32'(done_busy), 32'd0);
      chk({tag, "_post_idle"}, 32'(post_busy), 32'd0);
      chk({tag, "_t_hold"}, 32'(hold_err), 32'd0);
      chk({tag, "_vf_zero"}, 32'(vf_bad), 32'd0);
   endtask

   initial begin
      rd_b = '{BASE_A, BASE_C, BASE_A, BASE_C, BASE_T, BASE_A};
      rf_b = '{BASE_A, BASE_C, BASE_A, BASE_G, BASE_A, BASE_C, BASE_T, BASE_A};
      cyc = 0; poke = 1'b0;
      rst = 1'b1; start = 1'b0; ref_len = '0; base_in = '0; base_valid = 1'b0;
      repeat (3) tick();
      chk("reset_outputs",
          32'({busy, done, base_ready, store_S_out, init_out, S_out, T_out, V_out, F_out}),
          32'd0);
      rst = 1'b0;
      tick();
      chk("idle_ready", 32'(base_ready), 32'd0);

      // Back-to-back stream
      run_job(8, 16'h0000);
      check_job("job8", 8, 7);

      // Bubbles before reference bases 3 and 4
      run_job(8, 16'h0018);
      check_job("gaps", 8, 9);
      chk("gap_bubble1", 32'(init_cyc[3] - init_cyc[2]), 32'd2);
      chk("gap_bubble2", 32'(init_cyc[4] - init_cyc[3]), 32'd2);

      // Empty reference goes straight from LOAD to DRAIN
      run_job(0, 16'h0000);
      check_job("len0", 0, 0);

      // Reset in the middle of LOAD
      clear_log();
      start = 1'b1; ref_len = LW'(8);
      tick();
      start = 1'b0;
      send_read();
      tick();
      chk("abort_in_load", 32'(store_S_out), 32'd1);
      rst = 1'b1;
      tick();
      chk("abort_outputs",
          32'({busy, done, base_ready, store_S_out, init_out, S_out, T_out}), 32'd0);
      rst = 1'b0;
      n_done = 0;
      post_busy = 0;
      repeat (12) begin
         tick();
         if (busy || base_ready) post_busy++;
      end
      chk("abort_no_done", 32'(n_done), 32'd0);
      chk("abort_stays_idle", 32'(post_busy), 32'd0);
      run_job(8, 16'h0000);
      check_job("after_abort", 8, 7);

      // Start held while busy and on the done cycle must be ignored
      poke = 1'b1;
      run_job(8, 16'h0000);
      poke = 1'b0;
      start = 1'b0;
      check_job("start_busy", 8, 7);
      tick();
      chk("start_busy_idle", 32'({busy, base_ready}), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sw_array_loader.md
Name: sw_array_loader

Overview:
- Front-end stage that feeds PE0 of the Smith-Waterman systolic array.
- Accepts one job: a start command plus a 2-bit base stream carrying NUM_PE short-read bases, then ref_len reference bases.
- Buffers the short read, shift-loads it into the PE chain over S/store_S, then streams reference bases over T/init.
- Drives the array's left-boundary V/F, then flushes the pipeline and signals done.

Parameters:
- NUM_PE, 8, number of PEs in the array; short-read length per job (≥2).
- SCORE_W, 10, width of V_out/F_out (matches PE score width).
- LEN_W, 16, width of ref_len and the reference counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle job start; ignored while busy=1
- ref_len  in  LEN_W  reference length, sampled when start is accepted
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- base_in  in  2  base: A=00, C=01, G=10, T=11
- base_valid  in  1  base_in valid
- base_ready  out  1  loader can accept base_in
- V_out  out  SCORE_W  boundary V to PE0; constant 0
- F_out  out  SCORE_W  boundary F to PE0; constant 0
- S_out  out  2  short-read base to PE0
- store_S_out  out  1  S_out valid/store strobe
- T_out  out  2  reference base to PE0
- init_out  out  1  T_out valid/compute strobe

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: every output is 0 and state=IDLE. Reset mid-job aborts immediately: no done pulse, buffer contents are don't-care.
- Handshake: a base transfers when base_valid & base_ready at a rising edge. base_ready is high only in CAPTURE and STREAM.
- IDLE: busy=0, base_ready=0.
  - When start=1, latch ref_len, clear counters, go to CAPTURE.
  - busy=1 from the next cycle.
- CAPTURE: base_ready=1. Write accepted bases into buffer[0..NUM_PE-1] in arrival order. On the NUM_PE-th handshake, go to LOAD.
- LOAD: base_ready=0, lasts exactly NUM_PE cycles.
  - store_S_out=1 on each cycle, beginning the cycle after the last capture handshake.
  - S_out presents buffer[NUM_PE-1], buffer[NUM_PE-2], ..., buffer[0] (reverse order, so buffer[i] ends in PE i).
  - init_out=0 throughout.
  - Then go to STREAM, or to DRAIN if latched ref_len=0.
- STREAM: base_ready=1.
  - Each handshake at edge n drives T_out=base, init_out=1 visible from edge n+1 for one cycle.
  - A cycle with no handshake drives init_out=0 (bubble); T_out holds its last value.
  - store_S_out=0. At least one init_out=0 cycle separates the last store from the first init.
  - After ref_len handshakes, go to DRAIN; base_ready drops at the edge the last base is accepted.
- DRAIN: base_ready=0, init_out=0 for NUM_PE cycles, so results propagate out of the array.
  - On the last drain cycle, done=1 for one cycle, busy=0 in that same cycle, then go to IDLE.
- Simultaneous start and done: start is ignored, because busy is still considered 1 that cycle.
- Counters:
  - capture/load pointer: clog2(NUM_PE) bits, no wrap past NUM_PE-1.
  - reference counter: LEN_W bits, compared against latched ref_len. ref_len=2^LEN_W-1 must work.
- V_out and F_out are held at 0 in all states.

Decomposition:
- sw_pkg holds:
  - base encodings BASE_A/C/G/T
  - loader state enum {IDLE, CAPTURE, LOAD, STREAM, DRAIN}
  - default NUM_PE and SCORE_W constants
- One sub-module: sw_read_buffer.
  - NUM_PE x 2-bit register file.
  - Write port: wr_en, wr_addr, wr_data.
  - Combinational read port: rd_addr.
  - The loader sequences its addresses.

Test Plan:
- NUM_PE=6, read bases 00,01,00,01,11,00 sent back-to-back after start -> store_S_out high for exactly 6 cycles with S_out = 00,11,01,00,01,00; init_out=0; base_ready=0 throughout LOAD.
- Same job with ref_len=8, reference bases 00,01,00,10,00,01,11,00 with base_valid always 1 -> T_out follows the same sequence with init_out=1 for 8 consecutive cycles, each one cycle after its handshake; then 6 init_out=0 cycles, then a single done pulse; busy falls with done.
- STREAM with base_valid low on cycles 3 and 5 -> init_out=0 on exactly the two cycles following those gaps, T_out held; exactly 8 init pulses total.
- ref_len=0 -> LOAD goes directly to DRAIN, no init_out pulse, done after 6 drain cycles.
- rst=1 asserted in the middle of LOAD -> next cycle all outputs 0, state IDLE, no done. A new start then completes a full job correctly.
- start pulsed while busy and on the done cycle -> ignored: no second job, busy stays 0 after done. V_out=F_out=0 throughout.
